branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-stage branch resolution unit: the producer side of the BTB write port and the consumer of the predictions the BTB makes in IF. It compares each resolved branch or jump in EX with the prediction carried down the pipeline. On a mismatch it raises a registered flush and redirect. It issues BTB write requests, keeps a 2-bit bimodal direction table that IF reads, and counts branches and mispredicts.

## Interface
- `PHT_ENTRIES`, default 16: direction-table entries, indexed by `pc[5:2]`. Must be a power of 2, at most 16.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `IF_pc`, in, 32: fetch PC used for the direction-table lookup.
- `IF_pred_taken`, out, 1: MSB of the counter selected by `IF_pc[5:2]`; combinational.
- `EX_valid`, in, 1: a valid instruction is in EX.
- `EX_Branch`, in, 1: the EX instruction is a conditional branch.
- `EX_Jump`, in, 1: the EX instruction is JAL/JALR. `EX_Branch` and `EX_Jump` are never both 1.
- `EX_pc`, in, 32: PC of the EX instruction.
- `EX_taken`, in, 1: actual branch outcome. Ignored for jumps, which are always taken.
- `EX_target`, in, 32: computed target address.
- `EX_pred_hit`, in, 1: BTB hit recorded in IF and carried to EX.
- `EX_pred_taken`, in, 1: IF redirected fetch to the predicted target.
- `EX_pred_target`, in, 32: target used in IF.
- `flush`, out, 1: squash IF/ID and refetch; registered.
- `redirect_pc`, out, 32: refetch address; meaningful only while `flush`=1.
- `btb_write`, out, 1: BTB write strobe; registered.
- `btb_pc`, out, 32: PC to write into the BTB.
- `btb_target`, out, 32: target to write into the BTB.
- `btb_branch`, out, 1: BTB line type; 1 = branch, 0 = jump.
- `branch_count`, out, 32: number of resolved branches plus jumps.
- `mispredict_count`, out, 32: number of mispredicts.

## Operation
- A resolve event (`res`) occurs when `EX_valid`=1 and the FSM is in RUN. Otherwise EX inputs are ignored.
- The actual taken bit is `act = EX_Jump | (EX_Branch & EX_taken)`.
- A mispredict occurs on `res` when either condition holds:
  - `act != EX_pred_taken`;
  - `act & EX_pred_taken & (EX_pred_target != EX_target)`.
  - This includes a non-branch instruction with `EX_pred_taken`=1 (aliasing), which redirects to `EX_pc+4`.
- Redirect address: `redirect_pc` = `act` ? `EX_target` : `EX_pc+4`, computed modulo 2^32.
- BTB write: on `res` with `act`=1 and (`!EX_pred_hit` or `EX_pred_target != EX_target`):
  - `btb_write`=1 for one cycle;
  - `btb_pc`=`EX_pc`, `btb_target`=`EX_target`, `btb_branch`=`EX_Branch`.
- Direction table: 2-bit saturating counters, reset to 2'b01 (weakly not-taken).
  - Updated on `res` with `EX_Branch`=1: increment if taken (saturate at 3), decrement if not taken (saturate at 0).
  - Jumps and non-branches do not update the table.
- Statistics counters:
  - `branch_count` increments on `res` with `EX_Branch|EX_Jump`.
  - `mispredict_count` increments on each mispredict.
  - Both wrap modulo 2^32.
- FSM states:
  - RUN: a mispredict on `res` moves to SHADOW; otherwise stay in RUN.
  - SHADOW: lasts exactly 1 cycle and ignores the EX instruction, which is wrong-path (it was in ID when the mispredict resolved). Then return to RUN.
  - There are no further shadow cycles; the flush removes everything younger.

## Timing
- Reset values: `flush`=0, `redirect_pc`=0, `btb_write`=0, `btb_pc`=0, `btb_target`=0, `btb_branch`=0, both counters 0, all table entries 01, FSM in RUN.
- Latency: for a mispredict resolved in cycle t, `flush` and `redirect_pc` are valid in t+1 for exactly 1 cycle, and the FSM is in SHADOW in t+1.
- A BTB write triggered in cycle t is presented in t+1 for exactly 1 cycle.
- `btb_write` and `flush` may assert in the same cycle.
- Table update is visible from t+1. An IF read of the same index in cycle t returns the old value; there is no bypass.
- Counter outputs update in t+1.
- A mispredict and a BTB write for the same instruction both occur; neither suppresses the other.
- `rst` asserted in any state, including SHADOW or during an active `flush`, returns everything to reset values on the next edge. No pending flush or write survives reset.

## Structure
- Shared package `branch_pkg`:
  - FSM state typedef (RUN, SHADOW);
  - `PHT_IDX_LSB`=2 and counter reset value 2'b01;
  - the branch/jump encoding of `btb_branch`, shared with the BTB.
- Sub-module `bimodal_pht`: counter array with 1 combinational read port, 1 update port, synchronous reset.
- `branch_resolver` holds the FSM, compare logic, output registers and statistics counters.

## Test plan
- Reset, then read all 16 indices → `IF_pred_taken`=0 everywhere; all outputs 0.
- Branch at `EX_pc`=0x100, taken, target 0x80, pred_hit=0, pred_taken=0:
  - t+1: `flush`=1, `redirect_pc`=0x80, `btb_write`=1, `btb_pc`=0x100, `btb_target`=0x80, `btb_branch`=1;
  - counters read 1/1;
  - PHT[0] becomes 2'b10, so `IF_pred_taken`=1 for `IF_pc`=0x100.
- Branch predicted taken to 0x80 resolves not-taken at 0x100 → `redirect_pc`=0x104, no `btb_write`, PHT[0] goes from 10 to 01.
- JAL at 0x200 with pred_hit=1, pred_taken=1, pred_target 0x300, actual target 0x340 → `flush`, `redirect_pc`=0x340, `btb_write` with `btb_branch`=0.
- Mispredict followed by a valid EX instruction (which would also mispredict) in the next cycle → that instruction is ignored (SHADOW): no second flush, counters unchanged. Same test asserting `rst` in the SHADOW cycle → all reset values next cycle.
- Four consecutive taken branches at 0x10 → PHT[4] saturates at 11. Preload `mispredict_count` to 0xFFFFFFFF by force, then one mispredict → count wraps to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolver and the BTB.
package branch_pkg;

  // Resolver control state: RUN resolves EX, SHADOW drops one wrong-path slot.
  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // Direction-table index starts at the word offset of the PC.
  localparam int PHT_IDX_LSB = 2;

  // Counters come out of reset weakly not-taken.
  localparam logic [1:0] PHT_CTR_RESET = 2'b01;
  localparam logic [1:0] PHT_CTR_MAX   = 2'b11;
  localparam logic [1:0] PHT_CTR_MIN   = 2'b00;

  // BTB line type encoding, shared with the BTB itself.
  localparam logic BTB_TYPE_BRANCH = 1'b1;
  localparam logic BTB_TYPE_JUMP   = 1'b0;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != PHT_CTR_MAX) nxt = ctr + 2'd1;
    end else begin
      if (ctr != PHT_CTR_MIN) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolver_pht.sv
// Bimodal direction table: 2-bit saturating counters, one combinational read
// port for IF and one update port driven by branch resolution in EX.
module bimodal_pht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_taken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  // At least two entries so the index is never zero bits wide.
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [1:0]       ctr [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc[PHT_IDX_LSB +: IDX_W];
  assign upd_idx = upd_pc[PHT_IDX_LSB +: IDX_W];

  // Only the index bits of the PCs select a counter; the rest are don't-care.
  assign unused_pc_bits = ^{rd_pc, upd_pc};

  // Prediction is the counter MSB; reads see the pre-update value (no bypass).
  always_comb begin
    rd_taken = ctr[rd_idx][1];
  end

  // Counter array: synchronous reset to weakly not-taken, else train on update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= PHT_CTR_RESET;
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= pht_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: compares the actual outcome of each branch
// or jump with the prediction made in IF, raises a registered flush/redirect
// on a mispredict, issues BTB writes, trains the direction table and keeps
// branch/mispredict statistics.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int PHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_pc,
  output logic        IF_pred_taken,
  input  logic        EX_valid,
  input  logic        EX_Branch,
  input  logic        EX_Jump,
  input  logic [31:0] EX_pc,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic        EX_pred_hit,
  input  logic        EX_pred_taken,
  input  logic [31:0] EX_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        btb_write,
  output logic [31:0] btb_pc,
  output logic [31:0] btb_target,
  output logic        btb_branch,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  state_t      state;
  state_t      state_next;
  logic        res;
  logic        act;
  logic        target_diff;
  logic        mispredict;
  logic        btb_req;
  logic        count_branch;
  logic        pht_upd;
  logic [31:0] redirect_next;

  bimodal_pht #(
    .ENTRIES (PHT_ENTRIES)
  ) u_pht (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (IF_pc),
    .rd_taken  (IF_pred_taken),
    .upd_en    (pht_upd),
    .upd_pc    (EX_pc),
    .upd_taken (EX_taken)
  );

  // Resolve compare: actual direction, mispredict detection, BTB write request.
  always_comb begin
    res           = EX_valid && (state == RUN);
    act           = EX_Jump | (EX_Branch & EX_taken);
    target_diff   = (EX_pred_target != EX_target);
    mispredict    = res && ((act != EX_pred_taken) || (act && EX_pred_taken && target_diff));
    btb_req       = res && act && (!EX_pred_hit || target_diff);
    count_branch  = res && (EX_Branch || EX_Jump);
    pht_upd       = res && EX_Branch;
    redirect_next = act ? EX_target : (EX_pc + 32'd4);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: a mispredict opens a single wrong-path shadow cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispredict) state_next = SHADOW;
      SHADOW:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Flush/redirect register; the address is only loaded when a flush is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= redirect_next;
    end
  end

  // BTB write port register; the line payload is captured with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_write  <= 1'b0;
      btb_pc     <= '0;
      btb_target <= '0;
      btb_branch <= 1'b0;
    end else begin
      btb_write <= btb_req;
      if (btb_req) begin
        btb_pc     <= EX_pc;
        btb_target <= EX_target;
        btb_branch <= EX_Branch ? BTB_TYPE_BRANCH : BTB_TYPE_JUMP;
      end
    end
  end

  // Statistics counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (count_branch) branch_count     <= branch_count + 32'd1;
      if (mispredict)   mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver with a behavioural reference model
// and a per-cycle comparison process.
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic [31:0] IF_pc;
  logic        IF_pred_taken;
  logic        EX_valid;
  logic        EX_Branch;
  logic        EX_Jump;
  logic [31:0] EX_pc;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_pred_hit;
  logic        EX_pred_taken;
  logic [31:0] EX_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        btb_write;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        btb_branch;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 0;

  branch_resolver #(.PHT_ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_pc            (IF_pc),
    .IF_pred_taken    (IF_pred_taken),
    .EX_valid         (EX_valid),
    .EX_Branch        (EX_Branch),
    .EX_Jump          (EX_Jump),
    .EX_pc            (EX_pc),
    .EX_taken         (EX_taken),
    .EX_target        (EX_target),
    .EX_pred_hit      (EX_pred_hit),
    .EX_pred_taken    (EX_pred_taken),
    .EX_pred_target   (EX_pred_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .btb_write        (btb_write),
    .btb_pc           (btb_pc),
    .btb_target       (btb_target),
    .btb_branch       (btb_branch),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_pht [16];
  logic [31:0] m_branches;
  logic [31:0] m_misp;
  bit          m_shadow;
  bit          e_flush;
  logic [31:0] e_redirect;
  bit          e_btbw;
  logic [31:0] e_btb_pc;
  logic [31:0] e_btb_target;
  bit          e_btb_branch;
  bit          mv_res, mv_act, mv_wrong, mv_write;
  int          mv_idx;

  // Model: evaluates the resolution rules on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_pht[i] = 1;
      m_branches = 0;
      m_misp     = 0;
      m_shadow   = 0;
      e_flush    = 0;
      e_btbw     = 0;
    end else begin
      mv_res   = EX_valid && !m_shadow;
      mv_act   = EX_Jump || (EX_Branch && EX_taken);
      mv_wrong = mv_res && ((mv_act != EX_pred_taken) ||
                            (mv_act && EX_pred_taken && (EX_pred_target != EX_target)));
      mv_write = mv_res && mv_act && (!EX_pred_hit || (EX_pred_target != EX_target));
      e_flush = mv_wrong;
      if (mv_wrong) e_redirect = mv_act ? EX_target : EX_pc + 32'd4;
      e_btbw = mv_write;
      if (mv_write) begin
        e_btb_pc     = EX_pc;
        e_btb_target = EX_target;
        e_btb_branch = EX_Branch;
      end
      if (mv_res && (EX_Branch || EX_Jump)) m_branches = m_branches + 1;
      if (mv_wrong) m_misp = m_misp + 1;
      if (mv_res && EX_Branch) begin
        mv_idx = int'(EX_pc[5:2]);
        if (EX_taken) m_pht[mv_idx] = (m_pht[mv_idx] < 3) ? m_pht[mv_idx] + 1 : 3;
        else          m_pht[mv_idx] = (m_pht[mv_idx] > 0) ? m_pht[mv_idx] - 1 : 0;
      end
      m_shadow = mv_wrong;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: checks every output against the model on falling edges.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_pred_taken", {31'd0, IF_pred_taken}, {31'd0, m_pht[IF_pc[5:2]] >= 2});
      checkOutput("m_flush", {31'd0, flush}, {31'd0, e_flush});
      checkOutput("m_btb_write", {31'd0, btb_write}, {31'd0, e_btbw});
      checkOutput("m_branch_count", branch_count, m_branches);
      checkOutput("m_mispredict_count", mispredict_count, m_misp);
      if (e_flush) checkOutput("m_redirect_pc", redirect_pc, e_redirect);
      if (e_btbw) begin
        checkOutput("m_btb_pc", btb_pc, e_btb_pc);
        checkOutput("m_btb_target", btb_target, e_btb_target);
        checkOutput("m_btb_branch", {31'd0, btb_branch}, {31'd0, e_btb_branch});
      end
    end
  end

  task automatic setIdle();
    EX_valid       = 1'b0;
    EX_Branch      = 1'b0;
    EX_Jump        = 1'b0;
    EX_pc          = 32'd0;
    EX_taken       = 1'b0;
    EX_target      = 32'd0;
    EX_pred_hit    = 1'b0;
    EX_pred_taken  = 1'b0;
    EX_pred_target = 32'd0;
  endtask

  // Drives one EX slot for one cycle; returns #1 after the edge with EX idle.
  task automatic applyStimulus(input logic v, input logic br, input logic jp,
                               input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic hit,
                               input logic ptk, input logic [31:0] ptgt);
    EX_valid       = v;
    EX_Branch      = br;
    EX_Jump        = jp;
    EX_pc          = pc;
    EX_taken       = tk;
    EX_target      = tgt;
    EX_pred_hit    = hit;
    EX_pred_taken  = ptk;
    EX_pred_target = ptgt;
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    IF_pc = 32'd0;
    setIdle();
    idleCycles(2);
    rst = 1'b0;
    check_en = 1;

    // Reset state: all outputs zero, every index predicts not-taken
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_redirect", redirect_pc, 32'd0);
    checkOutput("rst_btb_write", {31'd0, btb_write}, 32'd0);
    checkOutput("rst_btb_pc", btb_pc, 32'd0);
    checkOutput("rst_btb_target", btb_target, 32'd0);
    checkOutput("rst_btb_branch", {31'd0, btb_branch}, 32'd0);
    checkOutput("rst_branch_count", branch_count, 32'd0);
    checkOutput("rst_misp_count", mispredict_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      IF_pc = 32'(i) << 2;
      #1;
      checkOutput("rst_pht_read", {31'd0, IF_pred_taken}, 32'd0);
    end
    idleCycles(1);

    // Taken branch, not predicted: flush + BTB write, PHT[0] -> 10
    IF_pc = 32'h100;
    applyStimulus(1, 1, 0, 32'h100, 1, 32'h80, 0, 0, 32'h0);
    checkOutput("br_flush", {31'd0, flush}, 32'd1);
    checkOutput("br_redirect", redirect_pc, 32'h80);
    checkOutput("br_btb_write", {31'd0, btb_write}, 32'd1);
    checkOutput("br_btb_pc", btb_pc, 32'h100);
    checkOutput("br_btb_target", btb_target, 32'h80);
    checkOutput("br_btb_branch", {31'd0, btb_branch}, 32'd1);
    checkOutput("br_branch_count", branch_count, 32'd1);
    checkOutput("br_misp_count", mispredict_count, 32'd1);
    checkOutput("br_pht_taken", {31'd0, IF_pred_taken}, 32'd1);
    idleCycles(1);
    checkOutput("br_flush_pulse", {31'd0, flush}, 32'd0);

    // Predicted taken, resolves not-taken: redirect to fall-through, PHT[0] -> 01
    applyStimulus(1, 1, 0, 32'h100, 0, 32'h80, 1, 1, 32'h80);
    checkOutput("nt_flush", {31'd0, flush}, 32'd1);
    checkOutput("nt_redirect", redirect_pc, 32'h104);
    checkOutput("nt_btb_write", {31'd0, btb_write}, 32'd0);
    checkOutput("nt_pht", {31'd0, IF_pred_taken}, 32'd0);
    idleCycles(1);

    // JAL with stale BTB target: flush to real target and rewrite as jump
    applyStimulus(1, 0, 1, 32'h200, 0, 32'h340, 1, 1, 32'h300);
    checkOutput("jal_flush", {31'd0, flush}, 32'd1);
    checkOutput("jal_redirect", redirect_pc, 32'h340);
    checkOutput("jal_btb_write", {31'd0, btb_write}, 32'd1);
    checkOutput("jal_btb_branch", {31'd0, btb_branch}, 32'd0);
    checkOutput("jal_branch_count", branch_count, 32'd3);
    idleCycles(1);

    // Mispredict then a would-be mispredict in the shadow slot: ignored
    applyStimulus(1, 1, 0, 32'h400, 1, 32'h500, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 32'h600, 0, 32'h700, 0, 0, 32'h0);
    checkOutput("sh_flush", {31'd0, flush}, 32'd0);
    checkOutput("sh_btb_write", {31'd0, btb_write}, 32'd0);
    checkOutput("sh_branch_count", branch_count, 32'd4);
    checkOutput("sh_misp_count", mispredict_count, 32'd4);
    idleCycles(1);

    // Same, but reset in the shadow cycle clears everything
    applyStimulus(1, 1, 0, 32'h400, 1, 32'h500, 0, 0, 32'h0);
    rst = 1'b1;
    applyStimulus(1, 0, 1, 32'h600, 0, 32'h700, 0, 0, 32'h0);
    rst = 1'b0;
    checkOutput("rs_flush", {31'd0, flush}, 32'd0);
    checkOutput("rs_redirect", redirect_pc, 32'd0);
    checkOutput("rs_btb_write", {31'd0, btb_write}, 32'd0);
    checkOutput("rs_btb_pc", btb_pc, 32'd0);
    checkOutput("rs_branch_count", branch_count, 32'd0);
    checkOutput("rs_misp_count", mispredict_count, 32'd0);
    checkOutput("rs_pht", {31'd0, IF_pred_taken}, 32'd0);

    // Four correctly predicted taken branches at 0x10: PHT[4] saturates at 11
    IF_pc = 32'h10;
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 32'h10, 1, 32'h40, 1, 1, 32'h40);
    checkOutput("sat_pred", {31'd0, IF_pred_taken}, 32'd1);
    checkOutput("sat_branch_count", branch_count, 32'd4);
    checkOutput("sat_misp_count", mispredict_count, 32'd0);
    applyStimulus(1, 1, 0, 32'h10, 0, 32'h40, 1, 0, 32'h0);
    checkOutput("sat_dec_11_10", {31'd0, IF_pred_taken}, 32'd1);
    applyStimulus(1, 1, 0, 32'h10, 0, 32'h40, 1, 0, 32'h0);
    checkOutput("sat_dec_10_01", {31'd0, IF_pred_taken}, 32'd0);

    // Correct taken prediction on a BTB miss: write without flush
    applyStimulus(1, 1, 0, 32'h800, 1, 32'h900, 0, 1, 32'h900);
    checkOutput("miss_flush", {31'd0, flush}, 32'd0);
    checkOutput("miss_btb_write", {31'd0, btb_write}, 32'd1);
    checkOutput("miss_btb_pc", btb_pc, 32'h800);

    // Mispredict counter wrap from 0xFFFFFFFF
    force dut.mispredict_count = 32'hFFFF_FFFF;
    m_misp = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_count;
    @(negedge clk);
    #1;
    applyStimulus(1, 1, 0, 32'h20, 1, 32'h40, 0, 0, 32'h0);
    checkOutput("wrap_misp_count", mispredict_count, 32'd0);
    idleCycles(1);

    // Aliased non-branch predicted taken: redirect to pc+4, no BTB write, no count
    applyStimulus(1, 0, 0, 32'h700, 0, 32'h0, 1, 1, 32'h900);
    checkOutput("alias_flush", {31'd0, flush}, 32'd1);
    checkOutput("alias_redirect", redirect_pc, 32'h704);
    checkOutput("alias_btb_write", {31'd0, btb_write}, 32'd0);
    idleCycles(1);

    // Fall-through address wraps modulo 2^32
    applyStimulus(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 1, 32'h1000);
    checkOutput("wrap_redirect", redirect_pc, 32'h0);
    idleCycles(2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
